// File: rtl/uart_pkg.sv
// Shared definitions for the configurable-baud UART pair (transmitter and receiver).
package uart_pkg;

  localparam int                BAUD_W    = 16;
  localparam int                DATA_BITS = 8;
  localparam logic [BAUD_W-1:0] MIN_BAUD  = 16'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a one-cycle falling-edge pulse.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1, s2, s2_q;

  // All stages reset high so the idle line never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1   <= rx;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  assign rx_s = s2;
  assign fall = s2_q & ~s2;

endmodule

// File: rtl/uart_rx_cfg_bd.sv
// 8N1 UART receiver with a runtime bit period, sticky ready flag, framing and overrun flags.
// Handshake: rdy stays high until clr_rdy is pulsed (or a new start edge is seen); clr_rdy is a one-cycle acknowledge.
module uart_rx_cfg_bd
  import uart_pkg::*;
#(
  parameter int                DATA_BITS = uart_pkg::DATA_BITS,
  parameter logic [BAUD_W-1:0] MIN_BAUD  = uart_pkg::MIN_BAUD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic [BAUD_W-1:0]    baud_cnt,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 ovr_err,
  output rx_state_t            dbg_state
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_t         state, state_nx;
  logic              rx_s, fall;
  logic [BAUD_W-1:0] bp, bp_eff, cnt;
  logic [BW-1:0]     bit_cnt;
  logic              unack;
  logic              expire, start_det, start_ok, shift_en, stop_done;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign bp_eff    = (baud_cnt < MIN_BAUD) ? MIN_BAUD : baud_cnt;
  assign expire    = (cnt <= 16'd1);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    stop_done = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          start_det = 1'b1;
          state_nx  = START;
        end
      end
      START: begin
        if (expire) begin
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            start_ok = 1'b1;
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_en = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1)) state_nx = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          stop_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit timing: half period to reach mid start bit, then whole periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp      <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
    end else begin
      if (start_det) begin
        bp  <= bp_eff;
        cnt <= bp_eff >> 1;
      end else if (state != IDLE) begin
        if (expire) cnt <= bp;
        else        cnt <= cnt - 16'd1;
      end
      if (start_ok)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BW'(1);
      if (shift_en) rx_data <= {rx_s, rx_data[DATA_BITS-1:1]};
    end
  end

  // rdy is also dropped at each start edge, so overrun is judged against
  // unack, which only an explicit clr_rdy acknowledges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
      unack   <= 1'b0;
    end else if (stop_done) begin
      rdy     <= 1'b1;
      frm_err <= ~rx_s;
      unack   <= 1'b1;
      if (!clr_rdy) ovr_err <= ovr_err | unack;
    end else begin
      if (clr_rdy || start_det) rdy <= 1'b0;
      if (start_det) frm_err <= 1'b0;
      if (clr_rdy) begin
        ovr_err <= 1'b0;
        unack   <= 1'b0;
      end
    end
  end

endmodule
